// File: rtl/id_stage_fwd_pkg.sv
// id_stage_fwd_pkg: shared widths, stall encoding, MIPS opcode/funct
// constants, ALU one-hot indices, operand-select bit positions and the
// decoded-control record used by the ID stage.
package id_stage_fwd_pkg;

    localparam int STALL_BUS_WD = 6;
    localparam int IF_TO_ID_WD  = 33;   // {ce, pc}
    localparam int BR_WD        = 33;   // {br_e, br_addr}
    localparam int REG_ADDR_W   = 5;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // One-hot alu_op bit positions, MSB first: add sub slt sltu and nor or xor sll srl sra lui
    localparam int ALU_ADD = 11;
    localparam int ALU_SUB = 10;
    localparam int ALU_SLT = 9;
    localparam int ALU_AND = 7;
    localparam int ALU_OR  = 5;
    localparam int ALU_SLL = 3;
    localparam int ALU_LUI = 0;

    // ALU source selects: src1 = {sa, pc, rs}; src2 = {zext imm, const 8, sext imm, rt}
    localparam int SRC1_RS   = 0;
    localparam int SRC1_PC   = 1;
    localparam int SRC1_SA   = 2;
    localparam int SRC2_RT   = 0;
    localparam int SRC2_SIMM = 1;
    localparam int SRC2_C8   = 2;
    localparam int SRC2_ZIMM = 3;

    typedef enum logic {HOLD_EMPTY = 1'b0, HOLD_HELD = 1'b1} hold_state_t;

    typedef struct packed {
        logic [11:0] alu_op;
        logic [2:0]  src1;
        logic [3:0]  src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic        reads_rs;
        logic        reads_rt;
    } ctrl_t;

    // Width of one {we, waddr, wdata} write/bypass channel.
    function automatic int ch_width(input int data_w);
        return data_w + 1 + REG_ADDR_W;
    endfunction

endpackage

// File: rtl/id_stage_fwd_operand_bypass.sv
// operand_bypass: priority mux resolving one source register.
//   addr     - source register number
//   fwd_bus  - NUM_FWD channels of {we, waddr, wdata}, channel 0 (EX) in the low bits
//   wb_bus   - regfile write port {we, waddr, wdata}, used as write-through
//   rf_rdata - regfile read data for addr
//   data     - resolved operand
// Priority: $0, lowest-index bypass hit, WB write-through, regfile.
module operand_bypass
    import id_stage_fwd_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int DATA_W  = 32
) (
    input  logic [4:0]                          addr,
    input  logic [NUM_FWD*ch_width(DATA_W)-1:0] fwd_bus,
    input  logic [ch_width(DATA_W)-1:0]         wb_bus,
    input  logic [DATA_W-1:0]                   rf_rdata,
    output logic [DATA_W-1:0]                   data
);
    localparam int CH_W = ch_width(DATA_W);

    logic [NUM_FWD-1:0] hit;
    logic [DATA_W-1:0]  ch_data [NUM_FWD];
    logic               wb_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FWD; gi++) begin : g_ch
            logic [CH_W-1:0] ch;
            assign ch          = fwd_bus[gi*CH_W +: CH_W];
            assign hit[gi]     = ch[CH_W-1] && (ch[CH_W-2 -: REG_ADDR_W] == addr);
            assign ch_data[gi] = ch[DATA_W-1:0];
        end
    endgenerate

    assign wb_hit = wb_bus[CH_W-1] && (wb_bus[CH_W-2 -: REG_ADDR_W] == addr);

    always_comb begin
        data = wb_hit ? wb_bus[DATA_W-1:0] : rf_rdata;
        // Walk from oldest to youngest so the youngest matching channel wins.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (hit[i]) data = ch_data[i];
        end
        if (addr == 5'd0) data = '0;
    end

endmodule

// File: rtl/id_stage_fwd.sv
// id_stage_fwd: MIPS decode stage with configurable bypass channels.
//   clk, rst (async, active-low)
//   stall[2:1]      - bit1 stops IF->ID capture, bit2 stops ID itself
//   flush           - synchronous kill of ID register and hold buffer
//   if_to_id_bus    - {ce, pc}; inst_sram_rdata arrives while that pc sits in ID
//   wb_to_rf_bus    - regfile write port {we, waddr, wdata}
//   fwd_bus         - NUM_FWD bypass channels, index 0 = EX
//   ex_is_load, ex_load_waddr - load in EX, for load-use detection
//   stallreq        - load-use stall request
//   id_to_ex_bus    - {pc, inst, alu_op, src1, src2, ram_en, ram_wen, rf_we, rf_waddr, sel_rf_res, rdata1, rdata2}
//   br_bus          - {br_e, br_addr}
module id_stage_fwd
    import id_stage_fwd_pkg::*;
#(
    parameter  int NUM_FWD     = 2,
    parameter  int DATA_W      = 32,
    localparam int WB_TO_RF_WD = ch_width(DATA_W),
    localparam int ID_TO_EX_WD = 95 + 2 * DATA_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [STALL_BUS_WD-1:0]        stall,
    input  logic                           flush,
    input  logic [IF_TO_ID_WD-1:0]         if_to_id_bus,
    input  logic [31:0]                    inst_sram_rdata,
    input  logic [WB_TO_RF_WD-1:0]         wb_to_rf_bus,
    input  logic [NUM_FWD*WB_TO_RF_WD-1:0] fwd_bus,
    input  logic                           ex_is_load,
    input  logic [4:0]                     ex_load_waddr,
    output logic                           stallreq,
    output logic [ID_TO_EX_WD-1:0]         id_to_ex_bus,
    output logic [BR_WD-1:0]               br_bus
);
    logic [IF_TO_ID_WD-1:0] id_bus_reg;
    hold_state_t            hold_state_reg;
    logic [31:0]            hold_inst_reg;
    logic [DATA_W-1:0]      rf_mem [32];

    logic        ce;
    logic [31:0] pc, pc_plus4, inst;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    ctrl_t       c;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic        br_hit, br_e;
    logic [31:0] br_target;
    logic        unused_stall;

    assign unused_stall = ^{stall[5:3], stall[0]};

    // ID register: a stopped IF feeding a running ID yields a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                      id_bus_reg <= '0;
        else if (flush)                                id_bus_reg <= '0;
        else if (stall[1] == STOP && stall[2] == NO_STOP) id_bus_reg <= '0;
        else if (stall[1] == NO_STOP)                  id_bus_reg <= if_to_id_bus;
    end

    // The SRAM returns the word only once, so capture it on the first stalled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_state_reg <= HOLD_EMPTY;
            hold_inst_reg  <= '0;
        end else if (flush) begin
            hold_state_reg <= HOLD_EMPTY;
            hold_inst_reg  <= '0;
        end else begin
            case (hold_state_reg)
                HOLD_EMPTY: if (stall[2] == STOP && ce) begin
                    hold_state_reg <= HOLD_HELD;
                    hold_inst_reg  <= inst_sram_rdata;
                end
                HOLD_HELD: if (stall[2] == NO_STOP) hold_state_reg <= HOLD_EMPTY;
                default:   hold_state_reg <= HOLD_EMPTY;
            endcase
        end
    end

    // Regfile: plain write port; reads go through the bypass for write-through.
    always_ff @(posedge clk) begin
        if (wb_to_rf_bus[WB_TO_RF_WD-1] && wb_to_rf_bus[WB_TO_RF_WD-2 -: 5] != 5'd0)
            rf_mem[wb_to_rf_bus[WB_TO_RF_WD-2 -: 5]] <= wb_to_rf_bus[DATA_W-1:0];
    end

    assign ce       = id_bus_reg[IF_TO_ID_WD-1];
    assign pc       = id_bus_reg[31:0];
    assign pc_plus4 = pc + 32'd4;
    assign inst     = !ce ? 32'd0 : (hold_state_reg == HOLD_HELD ? hold_inst_reg : inst_sram_rdata);
    assign opcode   = inst[31:26];
    assign rs       = inst[25:21];
    assign rt       = inst[20:16];
    assign rd       = inst[15:11];
    assign funct    = inst[5:0];

    always_comb begin
        c = '0;
        case (opcode)
            OP_SPECIAL: begin
                c.src1[SRC1_RS] = 1'b1;
                c.src2[SRC2_RT] = 1'b1;
                c.rf_we         = 1'b1;
                c.rf_waddr      = rd;
                c.reads_rs      = 1'b1;
                c.reads_rt      = 1'b1;
                case (funct)
                    FN_ADDU: c.alu_op[ALU_ADD] = 1'b1;
                    FN_SUBU: c.alu_op[ALU_SUB] = 1'b1;
                    FN_AND:  c.alu_op[ALU_AND] = 1'b1;
                    FN_OR:   c.alu_op[ALU_OR]  = 1'b1;
                    FN_SLT:  c.alu_op[ALU_SLT] = 1'b1;
                    FN_SLL: begin
                        c.alu_op[ALU_SLL] = 1'b1;
                        c.src1            = '0;
                        c.src1[SRC1_SA]   = 1'b1;
                        c.reads_rs        = 1'b0;
                    end
                    FN_JR: begin
                        c          = '0;
                        c.reads_rs = 1'b1;
                    end
                    default: c = '0;
                endcase
            end
            OP_ADDIU, OP_LW: begin
                c.alu_op[ALU_ADD]  = 1'b1;
                c.src1[SRC1_RS]    = 1'b1;
                c.src2[SRC2_SIMM]  = 1'b1;
                c.rf_we            = 1'b1;
                c.rf_waddr         = rt;
                c.reads_rs         = 1'b1;
                c.ram_en           = (opcode == OP_LW);
                c.sel_rf_res       = (opcode == OP_LW);
            end
            OP_ORI: begin
                c.alu_op[ALU_OR]   = 1'b1;
                c.src1[SRC1_RS]    = 1'b1;
                c.src2[SRC2_ZIMM]  = 1'b1;
                c.rf_we            = 1'b1;
                c.rf_waddr         = rt;
                c.reads_rs         = 1'b1;
            end
            OP_LUI: begin
                c.alu_op[ALU_LUI]  = 1'b1;
                c.src2[SRC2_ZIMM]  = 1'b1;
                c.rf_we            = 1'b1;
                c.rf_waddr         = rt;
            end
            OP_SW: begin
                c.alu_op[ALU_ADD]  = 1'b1;
                c.src1[SRC1_RS]    = 1'b1;
                c.src2[SRC2_SIMM]  = 1'b1;
                c.ram_en           = 1'b1;
                c.ram_wen          = 4'b1111;
                c.reads_rs         = 1'b1;
                c.reads_rt         = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                c.reads_rs = 1'b1;
                c.reads_rt = 1'b1;
            end
            OP_JAL: begin
                // Link value pc+8 is computed by the ALU as pc + const 8.
                c.alu_op[ALU_ADD]  = 1'b1;
                c.src1[SRC1_PC]    = 1'b1;
                c.src2[SRC2_C8]    = 1'b1;
                c.rf_we            = 1'b1;
                c.rf_waddr         = 5'd31;
            end
            default: c = '0;
        endcase
    end

    operand_bypass #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W)) u_bypass_rs (
        .addr(rs), .fwd_bus(fwd_bus), .wb_bus(wb_to_rf_bus), .rf_rdata(rf_mem[rs]), .data(rdata1)
    );
    operand_bypass #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W)) u_bypass_rt (
        .addr(rt), .fwd_bus(fwd_bus), .wb_bus(wb_to_rf_bus), .rf_rdata(rf_mem[rt]), .data(rdata2)
    );

    assign stallreq = ce && ex_is_load && (ex_load_waddr != 5'd0) &&
                      ((c.reads_rs && ex_load_waddr == rs) || (c.reads_rt && ex_load_waddr == rt));

    always_comb begin
        br_hit    = 1'b0;
        br_target = '0;
        if ((opcode == OP_BEQ && rdata1 == rdata2) || (opcode == OP_BNE && rdata1 != rdata2)) begin
            br_hit    = 1'b1;
            br_target = pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00};
        end else if (opcode == OP_J || opcode == OP_JAL) begin
            br_hit    = 1'b1;
            br_target = {pc_plus4[31:28], inst[25:0], 2'b00};
        end else if (opcode == OP_SPECIAL && funct == FN_JR) begin
            br_hit    = 1'b1;
            br_target = rdata1[31:0];
        end
    end

    // A branch whose operand is still being loaded must not redirect fetch yet.
    assign br_e   = ce && br_hit && !stallreq;
    assign br_bus = {br_e, br_e ? br_target : 32'd0};

    // An empty slot (ce=0) presents an all-zero bus rather than a decoded sll $0 nop.
    assign id_to_ex_bus = !ce ? '0 :
        {pc, inst, c.alu_op, c.src1, c.src2, c.ram_en, c.ram_wen,
         c.rf_we, c.rf_waddr, c.sel_rf_res, rdata1, rdata2};

endmodule

// File: tb/tb_id_stage_fwd.sv
module tb_id_stage_fwd;
    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [32:0] if_to_id_bus;
    logic [31:0] inst_sram_rdata;
    logic [37:0] wb_to_rf_bus;
    logic [75:0] fwd_bus;
    logic        ex_is_load;
    logic [4:0]  ex_load_waddr;
    logic        stallreq;
    logic [158:0] id_to_ex_bus;
    logic [32:0] br_bus;

    logic [31:0] o_pc, o_inst, o_rdata1, o_rdata2;
    logic [11:0] o_alu_op;
    logic [2:0]  o_src1;
    logic [3:0]  o_src2, o_ram_wen;
    logic        o_ram_en, o_rf_we, o_sel_rf_res;
    logic [4:0]  o_rf_waddr;
    logic        br_e;
    logic [31:0] br_addr;

    int errors = 0;
    int checks = 0;

    assign {o_pc, o_inst, o_alu_op, o_src1, o_src2, o_ram_en, o_ram_wen,
            o_rf_we, o_rf_waddr, o_sel_rf_res, o_rdata1, o_rdata2} = id_to_ex_bus;
    assign {br_e, br_addr} = br_bus;

    id_stage_fwd #(.NUM_FWD(2), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_to_id_bus(if_to_id_bus), .inst_sram_rdata(inst_sram_rdata),
        .wb_to_rf_bus(wb_to_rf_bus), .fwd_bus(fwd_bus),
        .ex_is_load(ex_is_load), .ex_load_waddr(ex_load_waddr),
        .stallreq(stallreq), .id_to_ex_bus(id_to_ex_bus), .br_bus(br_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture pc into ID, then present the instruction word one cycle later.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] word);
        if_to_id_bus = {1'b1, pc};
        stall = 6'b0;
        step();
        inst_sram_rdata = word;
        if_to_id_bus = 33'd0;
        #1;
        $display("fetch pc=%h inst=%h", pc, word);
    endtask

    task automatic clear_inputs();
        stall = 6'b0; flush = 1'b0; fwd_bus = '0; wb_to_rf_bus = '0;
        ex_is_load = 1'b0; ex_load_waddr = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0; clear_inputs();
        if_to_id_bus = {1'b1, 32'hBFC00000}; inst_sram_rdata = 32'hFFFFFFFF;
        ex_is_load = 1'b1; ex_load_waddr = 5'd31;
        step(); step();
        checks++; if (id_to_ex_bus !== '0) begin errors++; $display("FAIL reset_id_to_ex got=%h want=0", id_to_ex_bus); end
        checks++; if (br_bus !== 33'd0) begin errors++; $display("FAIL reset_br_bus got=%h want=0", br_bus); end
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq got=%b want=0", stallreq); end
        rst = 1'b1; clear_inputs(); if_to_id_bus = 33'd0;
    endtask

    task automatic test_alu_decode();
        fwd_bus = {38'd0, 1'b1, 5'd0, 32'hDEAD};       // EX targets $0: must be ignored
        fetch(32'hBFC00000, 32'h24010005);               // addiu $1,$0,5
        checks++; if (o_pc !== 32'hBFC00000) begin errors++; $display("FAIL addiu_pc got=%h want=bfc00000", o_pc); end
        checks++; if (o_inst !== 32'h24010005) begin errors++; $display("FAIL addiu_inst got=%h want=24010005", o_inst); end
        checks++; if (o_rdata1 !== 32'd0) begin errors++; $display("FAIL addiu_rs_zero got=%h want=0", o_rdata1); end
        checks++; if ({o_alu_op, o_src1, o_src2, o_rf_we, o_rf_waddr} !== {12'h800, 3'b001, 4'b0010, 1'b1, 5'd1}) begin
            errors++; $display("FAIL addiu_ctrl got=%h/%b/%b/%b/%0d want=800/001/0010/1/1", o_alu_op, o_src1, o_src2, o_rf_we, o_rf_waddr); end
        fwd_bus = {38'd0, 1'b1, 5'd1, 32'd5};
        fetch(32'hBFC00004, 32'h00211021);               // addu $2,$1,$1
        checks++; if (o_rdata1 !== 32'd5) begin errors++; $display("FAIL addu_rdata1 got=%h want=5", o_rdata1); end
        checks++; if (o_rdata2 !== 32'd5) begin errors++; $display("FAIL addu_rdata2 got=%h want=5", o_rdata2); end
        checks++; if (o_rf_waddr !== 5'd2) begin errors++; $display("FAIL addu_waddr got=%0d want=2", o_rf_waddr); end
        checks++; if (o_src2 !== 4'b0001) begin errors++; $display("FAIL addu_src2 got=%b want=0001", o_src2); end
        fetch(32'hBFC00008, 32'hFC000000);               // unknown opcode
        checks++; if ({o_rf_we, o_alu_op} !== 13'd0) begin errors++; $display("FAIL unknown_ctrl got=%b/%h want=0/000", o_rf_we, o_alu_op); end
        fetch(32'hBFC0000C, 32'h8C240000);               // lw $4,0($1)
        checks++; if ({o_ram_en, o_sel_rf_res, o_ram_wen, o_rf_we, o_rf_waddr} !== {1'b1, 1'b1, 4'b0000, 1'b1, 5'd4}) begin
            errors++; $display("FAIL lw_ctrl got=%b/%b/%b/%b/%0d want=1/1/0000/1/4", o_ram_en, o_sel_rf_res, o_ram_wen, o_rf_we, o_rf_waddr); end
        clear_inputs();
    endtask

    task automatic test_fwd_priority();
        fwd_bus = {1'b1, 5'd3, 32'd9, 1'b1, 5'd3, 32'd7}; // MEM=9, EX=7
        fetch(32'hBFC00020, 32'h00632821);               // addu $5,$3,$3
        checks++; if (o_rdata1 !== 32'd7) begin errors++; $display("FAIL ex_over_mem got=%h want=7", o_rdata1); end
        fwd_bus = {1'b1, 5'd3, 32'd9, 1'b0, 5'd3, 32'd7};
        #1;
        checks++; if (o_rdata2 !== 32'd9) begin errors++; $display("FAIL mem_only got=%h want=9", o_rdata2); end
        fwd_bus = '0;
        wb_to_rf_bus = {1'b1, 5'd3, 32'h11};
        #1;
        checks++; if (o_rdata1 !== 32'h11) begin errors++; $display("FAIL wb_write_through got=%h want=11", o_rdata1); end
        fetch(32'hBFC00024, 32'h00632821);               // the edge commits $3=0x11
        wb_to_rf_bus = '0;
        #1;
        checks++; if (o_rdata1 !== 32'h11) begin errors++; $display("FAIL regfile_read got=%h want=11", o_rdata1); end
        wb_to_rf_bus = {1'b1, 5'd3, 32'h22};
        #1;
        checks++; if (o_rdata2 !== 32'h22) begin errors++; $display("FAIL wb_over_rf got=%h want=22", o_rdata2); end
        fwd_bus = {38'd0, 1'b1, 5'd3, 32'd7};
        #1;
        checks++; if (o_rdata1 !== 32'd7) begin errors++; $display("FAIL ex_over_wb got=%h want=7", o_rdata1); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        fwd_bus = {38'd0, 1'b1, 5'd4, 32'd0};
        ex_is_load = 1'b1; ex_load_waddr = 5'd4;
        fetch(32'hBFC00100, 32'h10800003);               // beq $4,$0,3
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL loaduse_stallreq got=%b want=1", stallreq); end
        checks++; if (br_bus !== 33'd0) begin errors++; $display("FAIL loaduse_br_gated got=%h want=0", br_bus); end
        stall = 6'b000110;
        step();
        stall = 6'b0; ex_is_load = 1'b0;
        #1;
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL after_load_stallreq got=%b want=0", stallreq); end
        checks++; if (br_bus !== {1'b1, 32'hBFC00110}) begin errors++; $display("FAIL beq_taken got=%h want=1bfc00110", br_bus); end
        fwd_bus = {38'd0, 1'b1, 5'd4, 32'd5};
        #1;
        checks++; if (br_bus !== 33'd0) begin errors++; $display("FAIL beq_not_taken got=%h want=0", br_bus); end
        clear_inputs();
        ex_is_load = 1'b1; ex_load_waddr = 5'd1;
        fetch(32'hBFC00104, 32'h24010005);               // addiu $1,$0,5: rt is a destination
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL rt_not_read got=%b want=0", stallreq); end
        ex_load_waddr = 5'd0;
        fetch(32'hBFC00108, 32'h00001021);               // addu $2,$0,$0 with load to $0
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL load_to_zero got=%b want=0", stallreq); end
        clear_inputs();
    endtask

    task automatic test_hold();
        fetch(32'hBFC00200, 32'h00632821);
        stall = 6'b000110;
        step(); inst_sram_rdata = 32'h8C240000; #1;
        checks++; if (o_inst !== 32'h00632821) begin errors++; $display("FAIL hold_cycle1 got=%h want=00632821", o_inst); end
        step(); inst_sram_rdata = 32'hFC000000; #1;
        checks++; if (o_inst !== 32'h00632821) begin errors++; $display("FAIL hold_cycle2 got=%h want=00632821", o_inst); end
        step(); inst_sram_rdata = 32'h12345678; #1;
        checks++; if (o_inst !== 32'h00632821) begin errors++; $display("FAIL hold_cycle3 got=%h want=00632821", o_inst); end
        stall = 6'b0;
        #1;
        checks++; if ({o_pc, o_inst} !== {32'hBFC00200, 32'h00632821}) begin errors++; $display("FAIL hold_release got=%h/%h want=bfc00200/00632821", o_pc, o_inst); end
        clear_inputs();
    endtask

    task automatic test_jumps();
        fetch(32'hBFC00010, 32'h0C000040);               // jal 0x40
        checks++; if (br_bus !== {1'b1, 32'hB0000100}) begin errors++; $display("FAIL jal_br got=%h want=1b0000100", br_bus); end
        checks++; if ({o_rf_we, o_rf_waddr, o_alu_op, o_src1, o_src2} !== {1'b1, 5'd31, 12'h800, 3'b010, 4'b0100}) begin
            errors++; $display("FAIL jal_ctrl got=%b/%0d/%h/%b/%b want=1/31/800/010/0100", o_rf_we, o_rf_waddr, o_alu_op, o_src1, o_src2); end
        fwd_bus = {38'd0, 1'b1, 5'd31, 32'h12345678};
        fetch(32'hBFC00014, 32'h03E00008);               // jr $31
        checks++; if (br_bus !== {1'b1, 32'h12345678}) begin errors++; $display("FAIL jr_br got=%h want=112345678", br_bus); end
        checks++; if (o_rf_we !== 1'b0) begin errors++; $display("FAIL jr_rf_we got=%b want=0", o_rf_we); end
        clear_inputs();
    endtask

    task automatic test_bubble_flush();
        fetch(32'hBFC00300, 32'h24010005);
        stall = 6'b000010;
        step();
        checks++; if (id_to_ex_bus !== '0) begin errors++; $display("FAIL bubble got=%h want=0", id_to_ex_bus); end
        fetch(32'hBFC00304, 32'h24010005);
        stall = 6'b000110; flush = 1'b1;
        step();
        stall = 6'b0; flush = 1'b0;
        #1;
        checks++; if (id_to_ex_bus !== '0) begin errors++; $display("FAIL flush_over_stall got=%h want=0", id_to_ex_bus); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        ex_is_load = 1'b1; ex_load_waddr = 5'd1;
        fetch(32'hBFC00400, 32'h00211021);               // addu $2,$1,$1
        stall = 6'b000110;
        step();
        inst_sram_rdata = 32'hFC000000;
        #1;
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL pre_reset_stallreq got=%b want=1", stallreq); end
        rst = 1'b0; flush = 1'b1;
        #1;
        checks++; if ({id_to_ex_bus, br_bus, stallreq} !== '0) begin errors++; $display("FAIL async_reset got=%h/%h/%b want=0", id_to_ex_bus, br_bus, stallreq); end
        step();
        rst = 1'b1; flush = 1'b0; ex_is_load = 1'b0;
        if_to_id_bus = {1'b1, 32'hBFC00500};
        stall = 6'b000100;                                // ID captures, hold must already be EMPTY
        step();
        inst_sram_rdata = 32'h24010005;
        #1;
        checks++; if (o_inst !== 32'h24010005) begin errors++; $display("FAIL hold_cleared_by_reset got=%h want=24010005", o_inst); end
        clear_inputs();
    endtask

    initial begin
        if_to_id_bus = 33'd0; inst_sram_rdata = 32'd0;
        clear_inputs();
        test_reset();
        test_alu_decode();
        test_fwd_priority();
        test_load_use();
        test_hold();
        test_jumps();
        test_bubble_flush();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
